// File: rtl/dma_controller_wr_fsm_pkg.sv
// Shared types and constants for the DMA write-side FSM.
// Holds the FSM state encoding and the line/page geometry.
package dma_controller_wr_fsm_pkg;

    localparam int LINE_BYTES = 64;
    localparam int PAGE_BYTES = 4096;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_START_BURST,
        WR_BURST,
        WR_DISCARD_PAD,
        WR_DONE,
        XXX
    } wr_state_e;

endpackage

// File: rtl/dma_controller_wr_fsm_if.sv
// Read-data stream plus Avalon-MM burst write bus.
// master: write FSM side; slave: source/interconnect side.
interface dma_controller_wr_fsm_if #(
    parameter int DATA_W       = 512,
    parameter int ADDR_W       = 48,
    parameter int BURSTCOUNT_W = 7
);

    logic                    rd_data_valid;
    logic [DATA_W-1:0]       rd_data;
    logic                    rd_data_ready;
    logic [ADDR_W-1:0]       wr_address;
    logic                    wr_write;
    logic [DATA_W-1:0]       wr_writedata;
    logic [DATA_W/8-1:0]     wr_byteenable;
    logic [BURSTCOUNT_W-1:0] wr_burstcount;
    logic                    wr_waitrequest;

    modport master (
        input  rd_data_valid, rd_data, wr_waitrequest,
        output rd_data_ready, wr_address, wr_write,
        output wr_writedata, wr_byteenable, wr_burstcount
    );

    modport slave (
        output rd_data_valid, rd_data, wr_waitrequest,
        input  rd_data_ready, wr_address, wr_write,
        input  wr_writedata, wr_byteenable, wr_burstcount
    );

endinterface

// File: rtl/dma_controller_wr_fsm_burst_calc.sv
// Burst length = min(MAX_BURST, remaining, lines left in 4 KB page).
// Ports: page_line (line index in page), remaining (lines), burst.
module dma_wr_burst_calc
    import dma_controller_wr_fsm_pkg::*;
#(
    parameter int LEN_W        = 32,
    parameter int BURSTCOUNT_W = 7,
    parameter int MAX_BURST    = 64
) (
    input  logic [5:0]              page_line,
    input  logic [LEN_W-1:0]        remaining,
    output logic [BURSTCOUNT_W-1:0] burst
);

    localparam int PAGE_LINES = PAGE_BYTES / LINE_BYTES;

    logic [LEN_W-1:0] to_page;
    logic [LEN_W-1:0] limit;
    logic [LEN_W-1:0] pick;

    always_comb begin
        // Line index 0..63 gives 64..1 lines to the page end.
        to_page = LEN_W'(PAGE_LINES) - LEN_W'(page_line);
        limit   = (to_page < LEN_W'(MAX_BURST)) ? to_page
                                                 : LEN_W'(MAX_BURST);
        pick    = (remaining < limit) ? remaining : limit;
        burst   = BURSTCOUNT_W'(pick);
    end

endmodule

// File: rtl/dma_controller_wr_fsm.sv
// DMA write FSM: drains read-data lines into page-safe Avalon bursts.
// Ports: clk, reset_n, start/dst_addr/xfer_lines/pad_line, bus, busy, done.
module dma_controller_wr_fsm
    import dma_controller_wr_fsm_pkg::*;
#(
    parameter int DATA_W       = 512,
    parameter int ADDR_W       = 48,
    parameter int BURSTCOUNT_W = 7,
    parameter int MAX_BURST    = 64,
    parameter int LEN_W        = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     dst_addr,
    input  logic [LEN_W-1:0]      xfer_lines,
    input  logic                  pad_line,
    dma_controller_wr_fsm_if.master bus,
    output logic                  busy,
    output logic                  done
);

    localparam int BE_W = DATA_W / 8;

    wr_state_e state, state_n;

    logic [ADDR_W-1:0]       cur_addr;
    logic [ADDR_W-1:0]       addr_q;
    logic [LEN_W-1:0]        remaining;
    logic [BURSTCOUNT_W-1:0] beats_left;
    logic [BURSTCOUNT_W-1:0] bcount_q;
    logic [BURSTCOUNT_W-1:0] burst;
    logic                    pad_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    accept;
    logic                    last_beat;

    dma_wr_burst_calc #(
        .LEN_W        (LEN_W),
        .BURSTCOUNT_W (BURSTCOUNT_W),
        .MAX_BURST    (MAX_BURST)
    ) u_calc (
        .page_line (cur_addr[11:6]),
        .remaining (remaining),
        .burst     (burst)
    );

    assign bus.wr_writedata  = bus.rd_data;
    assign bus.wr_byteenable = {BE_W{1'b1}};
    assign bus.wr_address    = addr_q;
    assign bus.wr_burstcount = bcount_q;
    assign busy              = busy_q;
    assign done              = done_q;

    always_comb begin
        state_n           = state;
        accept            = 1'b0;
        bus.wr_write      = 1'b0;
        bus.rd_data_ready = 1'b0;
        last_beat         = (beats_left == BURSTCOUNT_W'(1));
        unique case (state)
            WR_IDLE: begin
                if (start) begin
                    if (xfer_lines != '0)
                        state_n = WR_START_BURST;
                    else if (pad_line)
                        state_n = WR_DISCARD_PAD;
                    else
                        state_n = WR_DONE;
                end
            end
            WR_START_BURST: begin
                state_n = WR_BURST;
            end
            WR_BURST: begin
                bus.wr_write      = bus.rd_data_valid;
                bus.rd_data_ready = !bus.wr_waitrequest;
                accept = bus.rd_data_valid && !bus.wr_waitrequest;
                if (accept && last_beat) begin
                    if (remaining != LEN_W'(1))
                        state_n = WR_START_BURST;
                    else if (pad_q)
                        state_n = WR_DISCARD_PAD;
                    else
                        state_n = WR_DONE;
                end
            end
            WR_DISCARD_PAD: begin
                bus.rd_data_ready = 1'b1;
                if (bus.rd_data_valid)
                    state_n = WR_DONE;
            end
            WR_DONE: begin
                state_n = WR_IDLE;
            end
            default: begin
                state_n = WR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= WR_IDLE;
            cur_addr   <= '0;
            addr_q     <= '0;
            remaining  <= '0;
            beats_left <= '0;
            bcount_q   <= '0;
            pad_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state  <= state_n;
            done_q <= (state_n == WR_DONE);
            if (state == WR_IDLE && start) begin
                cur_addr  <= dst_addr & ~ADDR_W'(LINE_BYTES - 1);
                remaining <= xfer_lines;
                pad_q     <= pad_line;
                busy_q    <= 1'b1;
            end
            if (state == WR_START_BURST) begin
                addr_q     <= cur_addr;
                bcount_q   <= burst;
                beats_left <= burst;
            end
            if (accept) begin
                beats_left <= beats_left - BURSTCOUNT_W'(1);
                remaining  <= remaining - LEN_W'(1);
                cur_addr   <= cur_addr + ADDR_W'(LINE_BYTES);
            end
            if (state == WR_DONE)
                busy_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dma_controller_wr_fsm.sv
// Directed self-checking bench for dma_controller_wr_fsm.
// Feeds tagged lines, records accepted writes, checks bursts and timing.
module tb_dma_controller_wr_fsm;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [47:0] dst_addr;
    logic [31:0] xfer_lines;
    logic        pad_line;
    logic        busy;
    logic        done;

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int done_count = 0;
    int done_cyc   = -1;
    int be_err     = 0;
    int sent;
    int first_fire;
    int last_fire;
    int s_cyc;

    logic [47:0]  m_addr[$];
    logic [6:0]   m_bc[$];
    logic [511:0] m_data[$];

    dma_controller_wr_fsm_if bus_if ();

    dma_controller_wr_fsm dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .dst_addr   (dst_addr),
        .xfer_lines (xfer_lines),
        .pad_line   (pad_line),
        .bus        (bus_if.master),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Writes accepted at the next rising edge, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus_if.wr_write && !bus_if.wr_waitrequest) begin
            m_addr.push_back(bus_if.wr_address);
            m_bc.push_back(bus_if.wr_burstcount);
            m_data.push_back(bus_if.wr_writedata);
            if (bus_if.wr_byteenable !== {64{1'b1}})
                be_err++;
        end
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_xfer(input logic [47:0] addr,
                            input int lines,
                            input bit pad,
                            input int offer,
                            input bit noisy,
                            input logic [31:0] dtag);
        m_addr.delete();
        m_bc.delete();
        m_data.delete();
        done_count = 0;
        done_cyc   = -1;
        sent       = 0;
        first_fire = -1;
        last_fire  = -1;
        dst_addr   = addr;
        xfer_lines = lines;
        pad_line   = pad;
        start      = 1'b1;
        @(negedge clk);
        s_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_on", busy, 1);
        for (int k = 0; k < 3000; k++) begin
            if (sent >= offer && done_count != 0)
                break;
            bus_if.rd_data_valid = (sent < offer) &&
                (!noisy || $urandom_range(0, 3) != 0);
            bus_if.rd_data = {16{dtag | 32'(sent)}};
            bus_if.wr_waitrequest = noisy &&
                ($urandom_range(0, 3) == 0);
            if (noisy && (k == 10 || k == 40))
                start = 1'b1;
            @(negedge clk);
            if (bus_if.rd_data_valid && bus_if.rd_data_ready) begin
                if (first_fire < 0)
                    first_fire = cyc;
                last_fire = cyc;
                sent++;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        bus_if.rd_data_valid  = 1'b0;
        bus_if.wr_waitrequest = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_beats(input string tag,
                               input int n,
                               input logic [31:0] dtag,
                               input logic [47:0] a0, input int b0,
                               input logic [47:0] a1, input int b1,
                               input logic [47:0] a2, input int b2);
        int errs;
        logic [47:0] ea;
        int eb;
        errs = 0;
        for (int i = 0; i < m_addr.size(); i++) begin
            if (i < b0) begin
                ea = a0;
                eb = b0;
            end else if (i < b0 + b1) begin
                ea = a1;
                eb = b1;
            end else begin
                ea = a2;
                eb = b2;
            end
            if (m_addr[i] !== ea || m_bc[i] !== 7'(eb) ||
                m_data[i] !== {16{dtag | 32'(i)}})
                errs++;
        end
        check({tag, "_count"}, m_addr.size(), n);
        check({tag, "_beats"}, errs, 0);
    endtask

    initial begin
        reset_n               = 1'b0;
        start                 = 1'b0;
        dst_addr              = '0;
        xfer_lines            = '0;
        pad_line              = 1'b0;
        bus_if.rd_data_valid  = 1'b0;
        bus_if.rd_data        = '0;
        bus_if.wr_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", bus_if.wr_address, 0);
        check("rst_bc", bus_if.wr_burstcount, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_write", bus_if.wr_write, 0);
        check("rst_ready", bus_if.rd_data_ready, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // single line at 0x1000
        run_xfer(48'h1000, 1, 0, 1, 0, 32'h0001_0000);
        check_beats("t1", 1, 32'h0001_0000,
                    48'h1000, 1, 48'h0, 0, 48'h0, 0);
        check("t1_first", first_fire, s_cyc + 2);
        check("t1_done_lat", done_cyc, last_fire + 1);
        check("t1_done_cnt", done_count, 1);
        check("t1_busy_off", busy, 0);

        // 130 lines: 64 + 64 + 2
        run_xfer(48'h0, 130, 0, 130, 0, 32'h0002_0000);
        check_beats("t2", 130, 32'h0002_0000,
                    48'h0, 64, 48'h1000, 64, 48'h2000, 2);
        check("t2_first", first_fire, s_cyc + 2);
        check("t2_done_lat", done_cyc, last_fire + 1);

        // unaligned request near page end: 1 + 2
        run_xfer(48'h0FDA, 3, 0, 3, 0, 32'h0003_0000);
        check_beats("t3", 3, 32'h0003_0000,
                    48'h0FC0, 1, 48'h1000, 2, 48'h0, 0);

        // pad line dropped
        run_xfer(48'h2000, 4, 1, 5, 0, 32'h0004_0000);
        check_beats("t4", 4, 32'h0004_0000,
                    48'h2000, 4, 48'h0, 0, 48'h0, 0);
        check("t4_sent", sent, 5);
        check("t4_done_lat", done_cyc, last_fire + 1);

        // random stalls, stray starts, page split 63 + 1
        run_xfer(48'h40, 64, 0, 64, 1, 32'h0005_0000);
        check_beats("t5", 64, 32'h0005_0000,
                    48'h40, 63, 48'h1000, 1, 48'h0, 0);
        check("t5_done_cnt", done_count, 1);
        check("t5_busy_off", busy, 0);

        // zero-length transfer
        run_xfer(48'h5000, 0, 0, 0, 0, 32'h0006_0000);
        check("t6_writes", m_addr.size(), 0);
        check("t6_done_lat", done_cyc, s_cyc + 1);
        check("t6_done_cnt", done_count, 1);

        // reset in the middle of a burst
        dst_addr   = 48'h0;
        xfer_lines = 32'd100;
        pad_line   = 1'b0;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start                = 1'b0;
        bus_if.rd_data_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("t7_mid_write", bus_if.wr_write, 1);
        reset_n = 1'b0;
        #1;
        check("t7_rst_write", bus_if.wr_write, 0);
        check("t7_rst_ready", bus_if.rd_data_ready, 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_bc", bus_if.wr_burstcount, 0);
        check("t7_rst_addr", bus_if.wr_address, 0);
        bus_if.rd_data_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_xfer(48'h3000, 2, 0, 2, 0, 32'h0008_0000);
        check_beats("t8", 2, 32'h0008_0000,
                    48'h3000, 2, 48'h0, 0, 48'h0, 0);
        check("t8_done_cnt", done_count, 1);
        check("byteenable", be_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
